// File: rtl/fft_seq_if.sv
// Pair-stream bundle for fft_frame_sequencer: source, FFT-core and sink. Master = sequencer side.
// Every bus is a 128-bit pair {x0_re,x0_im,x1_re,x1_im}; the sink has no backpressure.
interface fft_seq_if;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [127:0] s_data_i;
    logic         fft_start_o;
    logic [127:0] fft_x_o;
    logic         fft_ready_i;
    logic [127:0] fft_x_i;
    logic         m_valid_o;
    logic         m_last_o;
    logic [127:0] m_data_o;

    modport master (
        input  s_valid_i, s_data_i, fft_ready_i, fft_x_i,
        output s_ready_o, fft_start_o, fft_x_o, m_valid_o, m_last_o, m_data_o
    );

    modport slave (
        output s_valid_i, s_data_i, fft_ready_i, fft_x_i,
        input  s_ready_o, fft_start_o, fft_x_o, m_valid_o, m_last_o, m_data_o
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Buffers N/2 source pairs, streams them to the FFT core, forwards results with 1-cycle latency.
// Source is backpressured outside LOAD; optional WAIT timeout enabled by FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer #(
    parameter int N           = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        clr_err_i,
    fft_seq_if.master   bus,
    output logic        err_timeout_o,
    output logic        busy_o,
    output logic [2:0]  state_o,
    output logic [15:0] frame_cnt_o
);
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(HALF);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST_PAIR = cnt_t'(HALF - 1);
    // Result pair 0 is taken on the WAIT exit cycle, so UNLOAD only counts the remaining pairs.
    localparam cnt_t LAST_UNLD = cnt_t'(HALF - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FEED   = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    state_t       state;
    cnt_t         cnt;
    logic         s_ready_r;
    logic         start_r;
    logic [127:0] fft_x_r;
    logic         m_valid_r;
    logic         m_last_r;
    logic [127:0] m_data_r;
    logic [15:0]  frame_cnt;
    logic         accept;
    logic         timeout;
    logic [127:0] buf_mem [HALF];

    assign accept = bus.s_valid_i && s_ready_r;

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[cnt] <= bus.s_data_i;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wait_cnt;
    logic          err_r;

    // Ready on the expiring cycle still wins: timeout requires fft_ready_i low.
    assign timeout = (state == WAIT) && !bus.fft_ready_i &&
                     (wait_cnt == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            if (state == WAIT && !bus.fft_ready_i) begin
                wait_cnt <= wait_cnt + WW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                err_r <= 1'b1;
            end else if (clr_err_i) begin
                err_r <= 1'b0;
            end
        end
    end

    assign err_timeout_o = err_r;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic unused_clr_err;

    assign unused_clr_err = clr_err_i;
    assign timeout        = 1'b0;
    assign err_timeout_o  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_ready_r <= 1'b0;
            start_r   <= 1'b0;
            fft_x_r   <= '0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            frame_cnt <= '0;
        end else begin
            start_r   <= 1'b0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        s_ready_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == LAST_PAIR) begin
                            state     <= FEED;
                            cnt       <= '0;
                            s_ready_r <= 1'b0;
                            start_r   <= 1'b1;
                            fft_x_r   <= buf_mem[0];
                        end else begin
                            cnt <= cnt + cnt_t'(1);
                        end
                    end
                end
                FEED: begin
                    if (cnt == LAST_PAIR) begin
                        state   <= WAIT;
                        cnt     <= '0;
                        fft_x_r <= '0;
                    end else begin
                        cnt     <= cnt + cnt_t'(1);
                        fft_x_r <= buf_mem[cnt + cnt_t'(1)];
                    end
                end
                WAIT: begin
                    if (bus.fft_ready_i) begin
                        state     <= UNLOAD;
                        cnt       <= '0;
                        m_valid_r <= 1'b1;
                        m_data_r  <= bus.fft_x_i;
                    end else if (timeout) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                UNLOAD: begin
                    m_valid_r <= 1'b1;
                    m_data_r  <= bus.fft_x_i;
                    if (cnt == LAST_UNLD) begin
                        m_last_r  <= 1'b1;
                        cnt       <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                        if (enable_i) begin
                            state     <= LOAD;
                            s_ready_r <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.s_ready_o   = s_ready_r;
    assign bus.fft_start_o = start_r;
    assign bus.fft_x_o     = fft_x_r;
    assign bus.m_valid_o   = m_valid_r;
    assign bus.m_last_o    = m_last_r;
    assign bus.m_data_o    = m_data_r;
    assign busy_o          = (state != IDLE);
    assign state_o         = state;
    assign frame_cnt_o     = frame_cnt;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized frame-level bench: expected FEED and sink streams come from the pair/result lists.
// Compile with FFT_SEQ_TIMEOUT_EN to exercise the WAIT timeout instead of the indefinite wait.
module tb_fft_frame_sequencer;
    localparam int N    = 8;
    localparam int HALF = N / 2;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        clr_err_i;
    logic        err_timeout;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fft_seq_if bus ();

    fft_frame_sequencer #(.N(N), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .clr_err_i     (clr_err_i),
        .bus           (bus),
        .err_timeout_o (err_timeout),
        .busy_o        (busy),
        .state_o       (state),
        .frame_cnt_o   (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;
    bit hung = 0;

    logic [127:0] src [HALF];
    logic [127:0] res [HALF];
    logic         tr_start [HALF+1];
    logic [127:0] tr_x     [HALF+1];
    logic [2:0]   tr_state [HALF+1];
    logic         tr_srdy  [HALF+1];
    logic         tr_mv    [HALF+1];
    logic         tr_ml    [HALF+1];
    logic [127:0] tr_md    [HALF+1];
    logic [2:0]   st_end;
    bit           wait_bad;
    logic [280:0] rst_snap;
    int           post_mv;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [280:0] snap();
        return {bus.s_ready_o, bus.fft_start_o, bus.fft_x_o, bus.m_valid_o, bus.m_last_o,
                bus.m_data_o, busy, frame_cnt, err_timeout, state};
    endfunction

    task automatic fill(input bit seq);
        logic [127:0] t;
        for (int i = 0; i < HALF; i++) begin
            t      = r128();
            src[i] = seq ? {t[127:32], 32'(i + 1)} : t;
            res[i] = r128();
        end
    endtask

    task automatic do_load_feed(input int gmin, input int gmax, input bit drop_en);
        int g;
        int b;
        for (int i = 0; i < HALF; i++) begin
            g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
            if (g > 0) begin
                bus.s_valid_i = 1'b0;
                bus.s_data_i  = r128();
                repeat (g) step();
            end
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = src[i];
            b = 0;
            while (!bus.s_ready_o && b < 20) begin
                step();
                b++;
            end
            if (b >= 20) hung = 1;
            step();
        end
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = r128();
        for (int k = 0; k <= HALF; k++) begin
            tr_start[k] = bus.fft_start_o;
            tr_x[k]     = bus.fft_x_o;
            tr_state[k] = state;
            tr_srdy[k]  = bus.s_ready_o;
            if (drop_en && k == 0) enable_i = 1'b0;
            if (k < HALF) step();
        end
    endtask

    task automatic do_unload(input int wait_cyc, input int rst_at);
        wait_bad = 0;
        repeat (wait_cyc) begin
            bus.fft_ready_i = 1'b0;
            bus.fft_x_i     = r128();
            if (state !== 3'd3 || bus.m_valid_o !== 1'b0) wait_bad = 1;
            step();
        end
        for (int k = 0; k < HALF; k++) begin
            bus.fft_ready_i = (k == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            bus.fft_x_i     = res[k];
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                rst_snap = snap();
                step();
                rst = 1'b0;
                bus.fft_ready_i = 1'b0;
                post_mv = 0;
                repeat (HALF + 3) begin
                    if (bus.m_valid_o) post_mv++;
                    step();
                end
                return;
            end
            step();
            tr_mv[k] = bus.m_valid_o;
            tr_md[k] = bus.m_data_o;
            tr_ml[k] = bus.m_last_o;
            if (k == HALF - 1) st_end = state;
        end
        bus.fft_ready_i = 1'b0;
        bus.fft_x_i     = r128();
        step();
        tr_mv[HALF] = bus.m_valid_o;
        tr_ml[HALF] = bus.m_last_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_i = 1'b0; clr_err_i = 1'b0;
        bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.fft_ready_i = 1'b0; bus.fft_x_i = '0;
        #3;
        n_cmp++;
        if (snap() !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", snap());
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_cmp++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_without_enable: state %0d busy %0d want 0 0", state, busy);
        end
    endtask

    task automatic test_basic();
        fill(1);
        enable_i = 1'b1;
        step();
        n_cmp++;
        if (state !== 3'd1 || bus.s_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL enter_load: state %0d ready %0d want 1 1", state, bus.s_ready_o);
        end
        do_load_feed(0, 0, 0);
        do_unload(10, -1);
        exp_frames++;
        for (int k = 0; k <= HALF; k++) begin
            n_cmp++;
            if (tr_start[k] !== (k == 0) || tr_x[k] !== ((k < HALF) ? src[k] : 128'd0) ||
                tr_state[k] !== ((k < HALF) ? 3'd2 : 3'd3) || tr_srdy[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_feed[%0d]: start %0d x %h state %0d rdy %0d want start %0d x %h",
                         k, tr_start[k], tr_x[k], tr_state[k], tr_srdy[k], (k == 0),
                         (k < HALF) ? src[k] : 128'd0);
            end
        end
        n_cmp++;
        if (wait_bad) begin
            n_bad++; $display("FAIL basic_wait: state/m_valid wrong during WAIT, got flag 1 want 0");
        end
        for (int k = 0; k <= HALF; k++) begin
            n_cmp++;
            if (tr_mv[k] !== (k < HALF) || tr_ml[k] !== (k == HALF - 1) ||
                (k < HALF && tr_md[k] !== res[k])) begin
                n_bad++;
                $display("FAIL basic_sink[%0d]: v %0d l %0d d %h want v %0d l %0d d %h", k,
                         tr_mv[k], tr_ml[k], tr_md[k], (k < HALF), (k == HALF - 1),
                         (k < HALF) ? res[k] : 128'd0);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || st_end !== 3'd1) begin
            n_bad++; $display("FAIL basic_done: frames %0d state %0d want %0d 1", frame_cnt, st_end, exp_frames);
        end
    endtask

    task automatic test_gaps();
        fill(0);
        do_load_feed(3, 3, 0);
        do_unload(int'($urandom_range(5, 0)), -1);
        exp_frames++;
        for (int k = 0; k < HALF; k++) begin
            n_cmp++;
            if (tr_x[k] !== src[k] || tr_start[k] !== (k == 0)) begin
                n_bad++; $display("FAIL gaps_feed[%0d]: x %h start %0d want %h %0d", k, tr_x[k], tr_start[k], src[k], (k == 0));
            end
            n_cmp++;
            if (tr_md[k] !== res[k] || tr_mv[k] !== 1'b1) begin
                n_bad++; $display("FAIL gaps_sink[%0d]: d %h v %0d want %h 1", k, tr_md[k], tr_mv[k], res[k]);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || hung) begin
            n_bad++; $display("FAIL gaps_done: frames %0d hung %0d want %0d 0", frame_cnt, hung, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        for (int f = 0; f < 3; f++) begin
            fill(0);
            do_load_feed(0, 2, 0);
            do_unload(int'($urandom_range(3, 0)), -1);
            exp_frames++;
            errs = 0;
            for (int k = 0; k < HALF; k++) begin
                if (tr_x[k] !== src[k] || tr_md[k] !== res[k] || tr_ml[k] !== (k == HALF - 1)) errs++;
            end
            n_cmp++;
            if (errs != 0) begin
                n_bad++; $display("FAIL b2b_frame%0d: %0d bad pairs want 0", f, errs);
            end
            n_cmp++;
            if (frame_cnt !== 16'(exp_frames) || st_end !== 3'd1) begin
                n_bad++; $display("FAIL b2b_cnt%0d: frames %0d state %0d want %0d 1", f, frame_cnt, st_end, exp_frames);
            end
        end
    endtask

    task automatic test_enable_drop();
        fill(0);
        do_load_feed(0, 1, 1);
        do_unload(2, -1);
        exp_frames++;
        n_cmp++;
        if (st_end !== 3'd0 || tr_md[HALF-1] !== res[HALF-1] || tr_ml[HALF-1] !== 1'b1) begin
            n_bad++; $display("FAIL drop_complete: state %0d last %h want 0 %h", st_end, tr_md[HALF-1], res[HALF-1]);
        end
        step();
        n_cmp++;
        if (state !== 3'd0 || bus.s_ready_o !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL drop_idle: state %0d ready %0d busy %0d frames %0d want 0 0 0 %0d",
                              state, bus.s_ready_o, busy, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_wait_policy();
`ifdef FFT_SEQ_TIMEOUT_EN
        int c;
        enable_i = 1'b1;
        fill(0);
        do_load_feed(0, 0, 1);
        c = 0;
        while (state === 3'd3 && c < 100) begin
            bus.fft_ready_i = 1'b0;
            c++;
            step();
        end
        n_cmp++;
        if (c != TO || err_timeout !== 1'b1 || state !== 3'd0 || frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL timeout: wait %0d err %0d state %0d frames %0d want %0d 1 0 %0d",
                              c, err_timeout, state, frame_cnt, TO, exp_frames);
        end
        step();
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: err %0d want 1", err_timeout);
        end
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL timeout_clear: err %0d want 0", err_timeout);
        end
        enable_i = 1'b1;
        fill(0);
        do_load_feed(0, 0, 1);
        do_unload(TO - 1, -1);
        exp_frames++;
        n_cmp++;
        if (err_timeout !== 1'b0 || tr_md[0] !== res[0] || tr_md[HALF-1] !== res[HALF-1] ||
            frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL ready_wins: err %0d d0 %h frames %0d want 0 %h %0d",
                              err_timeout, tr_md[0], frame_cnt, res[0], exp_frames);
        end
`else
        enable_i = 1'b1;
        fill(0);
        do_load_feed(0, 0, 1);
        repeat (40) begin
            bus.fft_ready_i = 1'b0;
            clr_err_i = 1'($urandom_range(1, 0));
            step();
        end
        clr_err_i = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || err_timeout !== 1'b0 || bus.m_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL wait_indefinite: state %0d err %0d mv %0d want 3 0 0", state, err_timeout, bus.m_valid_o);
        end
        do_unload(0, -1);
        exp_frames++;
        n_cmp++;
        if (tr_md[0] !== res[0] || tr_md[HALF-1] !== res[HALF-1] || frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL late_ready: d0 %h frames %0d want %h %0d", tr_md[0], frame_cnt, res[0], exp_frames);
        end
`endif
    endtask

    task automatic test_reset_unload();
        enable_i = 1'b1;
        fill(0);
        do_load_feed(0, 0, 1);
        do_unload(3, 2);
        exp_frames = 0;
        n_cmp++;
        if (rst_snap !== '0) begin
            n_bad++; $display("FAIL reset_in_unload: outputs %h want 0", rst_snap);
        end
        n_cmp++;
        if (post_mv != 0 || state !== 3'd0 || frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL reset_discard: mv %0d state %0d frames %0d want 0 0 0", post_mv, state, frame_cnt);
        end
        n_cmp++;
        if (tr_md[0] !== res[0] || tr_md[1] !== res[1]) begin
            n_bad++; $display("FAIL reset_pre_pairs: %h %h want %h %h", tr_md[0], tr_md[1], res[0], res[1]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_enable_drop();
        test_wait_policy();
        test_reset_unload();
        n_cmp++;
        if (hung) begin
            n_bad++; $display("FAIL source_handshake: ready bound expired got 1 want 0");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning FFT points per frame (power of 2, >=4); one pair = 2 complex samples, N/2 pairs/frame.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, meaning max WAIT cycles before timeout (used only with FFT_SEQ_TIMEOUT_EN).
REQ-003 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable_i  in  1  allow new frames.
REQ-006 s_valid_i  in  1 / s_ready_o  out  1 / s_data_i  in  128  source pair {x0_re,x0_im,x1_re,x1_im}, MSB first.
REQ-007 fft_start_o  out  1 / fft_x_o  out  128  pair stream to FFT core.
REQ-008 fft_ready_i  in  1 / fft_x_i  in  128  result stream from FFT core.
REQ-009 m_valid_o  out  1 / m_last_o  out  1 / m_data_o  out  128  result sink, no backpressure.
REQ-010 clr_err_i  in  1 / err_timeout_o  out  1  sticky timeout flag and clear.
REQ-011 busy_o  out  1 (state != IDLE); state_o  out  3; frame_cnt_o  out  16 completed frames.

Function
REQ-012 States SHALL be IDLE=0, LOAD=1, FEED=2, WAIT=3, UNLOAD=4 on state_o.
REQ-013 IDLE->LOAD when enable_i=1.
REQ-014 LOAD: s_ready_o=1 only here; each s_valid_i&s_ready_o cycle writes s_data_i into internal N/2x128 buffer at pair index cnt, cnt++.
REQ-015 LOAD->FEED on acceptance of pair N/2-1; s_ready_o low from next cycle; source gaps tolerated.
REQ-016 FEED: fft_start_o SHALL pulse exactly one cycle, same cycle fft_x_o=pair 0; pairs 1..N/2-1 follow on consecutive cycles, no gaps; fft_x_o=0 outside FEED.
REQ-017 FEED->WAIT after pair N/2-1 driven.
REQ-018 WAIT->UNLOAD on first cycle fft_ready_i=1; that cycle's fft_x_i is result pair 0.
REQ-019 UNLOAD: fft_x_i sampled on N/2 consecutive cycles starting at WAIT exit cycle, fft_ready_i ignored after first.
REQ-020 m_valid_o/m_data_o SHALL be registered, latency 1 cycle from fft_x_i sample; m_last_o=1 with result pair N/2-1 only.
REQ-021 After last result sampled: frame_cnt_o++ (wraps 0xFFFF->0x0000); next state LOAD if enable_i=1 else IDLE.
REQ-022 enable_i deasserted mid-frame SHALL NOT abort; frame completes, then IDLE.
REQ-023 Pair counter width clog2(N/2), reset to 0 on every state change; never exceeds N/2-1.
REQ-024 Datapath passes 128-bit pairs unmodified; no arithmetic on samples.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, cnt 0, s_ready_o 0, fft_start_o 0, fft_x_o 0, m_valid_o 0, m_last_o 0, m_data_o 0, busy_o 0, frame_cnt_o 0, err_timeout_o 0; buffer contents undefined.
REQ-026 Reset mid-frame SHALL discard partial frame; no m_valid_o until a full new frame completes.

Configuration
REQ-027 Macro FFT_SEQ_TIMEOUT_EN defined: WAIT cycle counter; TIMEOUT_CYC consecutive WAIT cycles without fft_ready_i sets err_timeout_o, drops frame, goes IDLE, frame_cnt_o unchanged.
REQ-028 Same cycle counter expires and fft_ready_i=1: ready wins, UNLOAD, no error.
REQ-029 err_timeout_o sticky; cleared by clr_err_i=1 (clear wins over simultaneous set? no: set wins) or rst.
REQ-030 Macro undefined: no counter logic, err_timeout_o tied 0, clr_err_i ignored, WAIT indefinite.

Verification
REQ-031 N=8, enable_i=1, 4 pairs 0x..01..0x..04 back-to-back -> fft_start_o 1 cycle with pair 1, pairs 2-4 next 3 cycles, state LOAD->FEED->WAIT.
REQ-032 Source inserts 3-cycle gaps between pairs -> buffer order preserved, FEED stream still contiguous.
REQ-033 fft_ready_i rises 10 cycles into WAIT, fft_x_i=A,B,C,D -> m_valid_o 4 cycles starting 1 cycle later, data A..D, m_last_o with D, frame_cnt_o=1.
REQ-034 enable_i dropped during FEED -> frame completes, state IDLE after UNLOAD, s_ready_o stays 0.
REQ-035 FFT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, fft_ready_i held 0 -> err_timeout_o=1 after 16 WAIT cycles, state IDLE, frame_cnt_o unchanged; clr_err_i -> 0.
REQ-036 rst pulsed during UNLOAD pair 2 -> all outputs 0 same cycle, no further m_valid_o for that frame.
